// File: rtl/ram_req_sequencer.sv
// ram_req_sequencer: serialises write/read commands onto a single-port RAM, honouring its two-edge read latency.
module ram_req_sequencer #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              wr_done
);
    typedef enum logic [2:0] {IDLE, WR, RD_A, RD_B, RD_C, RSP} state_t;

    state_t            state_q, state_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              wr_done_q, wr_done_d;

    assign cmd_ready = state_q == IDLE;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign wr_done   = wr_done_q;

    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        wr_done_d   = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                mem_addr_d  = cmd_addr;
                mem_we_d    = cmd_we;
                mem_wdata_d = cmd_we ? cmd_wdata : mem_wdata_q;
                state_d     = cmd_we ? WR : RD_A;
            end
            WR: begin
                wr_done_d = 1'b1;
                state_d   = IDLE;
            end
            RD_A: state_d = RD_B;
            RD_B: state_d = RD_C;
            // RAM data is valid only after the second edge, so capture here
            RD_C: begin
                rsp_data_d  = mem_rdata;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            wr_done_q   <= wr_done_d;
        end
    end
endmodule

// File: tb/tb_ram_req_sequencer.sv
// tb_ram_req_sequencer: directed vectors, corner sequences and a randomized run against a transaction-level model.
module tb_ram_req_sequencer;
    logic       clk, rst;
    logic       cmd_valid, cmd_ready, cmd_we;
    logic       cmd_addr;
    logic [3:0] cmd_wdata;
    logic       mem_we, mem_addr;
    logic [3:0] mem_wdata, mem_rdata;
    logic       rsp_valid, rsp_ready, wr_done;
    logic [3:0] rsp_data;

    int total = 0;
    int bad = 0;

    ram_req_sequencer #(.DATA_W(4), .ADDR_W(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .wr_done(wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: write on mem_we edge; address latched one edge, data out after the next
    logic [3:0] ram [2];
    logic       ram_a;
    initial begin
        ram[0] = 4'd0;
        ram[1] = 4'd0;
        ram_a = 1'b0;
        mem_rdata = 4'd0;
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        ram_a <= mem_addr;
        mem_rdata <= ram[ram_a];
    end

    task automatic chk1(input string n, input logic a, input logic e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", n, a, e);
        end
    endtask

    task automatic chk4(input string n, input logic [3:0] a, input logic [3:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %b expected %b", n, a, e);
        end
    endtask

    task automatic chki(input string n, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string n);
        chk1({n, " cmd_ready"}, cmd_ready, 1'b1);
        chk1({n, " mem_we"}, mem_we, 1'b0);
        chk1({n, " mem_addr"}, mem_addr, 1'b0);
        chk4({n, " mem_wdata"}, mem_wdata, 4'd0);
        chk1({n, " rsp_valid"}, rsp_valid, 1'b0);
        chk4({n, " rsp_data"}, rsp_data, 4'd0);
        chk1({n, " wr_done"}, wr_done, 1'b0);
    endtask

    // Issues one command from IDLE and checks its full timing (caller sits #1 after an edge)
    task automatic do_cmd(input logic we, input logic a, input logic [3:0] wd, input logic [3:0] rd);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = wd; rsp_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk1("acc cmd_ready", cmd_ready, 1'b0);
        chk1("acc mem_addr", mem_addr, a);
        chk1("acc mem_we", mem_we, we);
        if (we) begin
            chk4("acc mem_wdata", mem_wdata, wd);
            step();
            chk1("wr mem_we drop", mem_we, 1'b0);
            chk1("wr_done pulse", wr_done, 1'b1);
            chk1("wr cmd_ready", cmd_ready, 1'b1);
            step();
            chk1("wr_done single", wr_done, 1'b0);
        end else begin
            repeat (2) begin
                step();
                chk1("rd early rsp_valid", rsp_valid, 1'b0);
                chk1("rd cmd_ready busy", cmd_ready, 1'b0);
            end
            step();
            chk1("rd rsp_valid", rsp_valid, 1'b1);
            chk4("rd rsp_data", rsp_data, rd);
            step();
            chk1("rd rsp_valid drop", rsp_valid, 1'b0);
            chk1("rd cmd_ready back", cmd_ready, 1'b1);
        end
    endtask

    typedef struct {
        logic       we;
        logic       addr;
        logic [3:0] wd;
        logic [3:0] rd;
    } vec_t;

    vec_t       tbl [7];
    vec_t       bb [4];
    int         acc [4];
    int         exp_acc [4];
    int         k;
    logic       r;
    logic [3:0] got [$];

    // Reference model: shadow memory plus cycles-since-acceptance of the current command
    logic [3:0] ref_mem [2];
    int         ph;
    logic       m_we, m_addr, e_done;
    logic [3:0] m_wd, m_rsp;

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 1'b0; cmd_wdata = 4'd0; rsp_ready = 1'b1;
        #2 rst = 1'b1;
        #1 check_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        tbl[0] = '{1'b1, 1'b0, 4'b0110, 4'b0000};
        tbl[1] = '{1'b1, 1'b1, 4'b1111, 4'b0000};
        tbl[2] = '{1'b0, 1'b0, 4'b0000, 4'b0110};
        tbl[3] = '{1'b0, 1'b1, 4'b0000, 4'b1111};
        tbl[4] = '{1'b0, 1'b0, 4'b0000, 4'b0110};
        tbl[5] = '{1'b1, 1'b0, 4'b1100, 4'b0000};
        tbl[6] = '{1'b0, 1'b0, 4'b0000, 4'b1100};
        for (int i = 0; i < 7; i++) do_cmd(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].rd);

        // Back-pressure: read addr1 with rsp_ready low, a write waiting on cmd_valid
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 1'b1; rsp_ready = 1'b0;
        step();
        cmd_we = 1'b1; cmd_wdata = 4'b0011;
        repeat (3) step();
        for (int i = 0; i < 7; i++) begin
            chk1("bp rsp_valid held", rsp_valid, 1'b1);
            chk4("bp rsp_data held", rsp_data, 4'b1111);
            chk1("bp cmd_ready low", cmd_ready, 1'b0);
            chk1("bp mem_we low", mem_we, 1'b0);
            if (i < 6) step();
        end
        rsp_ready = 1'b1;
        step();
        chk1("bp rsp_valid drop", rsp_valid, 1'b0);
        chk1("bp cmd_ready", cmd_ready, 1'b1);
        chk1("bp not yet accepted", mem_we, 1'b0);
        step();
        chk1("bp accepted mem_we", mem_we, 1'b1);
        chk1("bp accepted addr", mem_addr, 1'b1);
        chk4("bp accepted wdata", mem_wdata, 4'b0011);
        cmd_valid = 1'b0;
        step();
        chk1("bp wr_done", wr_done, 1'b1);
        step();

        // Back-to-back with cmd_valid held high
        bb[0] = '{1'b1, 1'b0, 4'b1010, 4'b0000};
        bb[1] = '{1'b0, 1'b0, 4'b0000, 4'b0000};
        bb[2] = '{1'b1, 1'b1, 4'b0101, 4'b0000};
        bb[3] = '{1'b0, 1'b1, 4'b0000, 4'b0000};
        exp_acc = '{0, 2, 7, 9};
        k = 0;
        rsp_ready = 1'b1;
        for (int t = 0; t < 16; t++) begin
            cmd_valid = k < 4;
            if (k < 4) begin
                cmd_we = bb[k].we; cmd_addr = bb[k].addr; cmd_wdata = bb[k].wd;
            end
            r = cmd_ready && cmd_valid;
            step();
            if (r) begin
                acc[k] = t;
                k++;
            end
            if (rsp_valid) got.push_back(rsp_data);
        end
        cmd_valid = 1'b0;
        chki("b2b accepted count", k, 4);
        for (int i = 0; i < 4; i++) chki("b2b accept edge", acc[i] - acc[0], exp_acc[i]);
        chki("b2b rsp count", got.size(), 2);
        if (got.size() == 2) begin
            chk4("b2b rsp0", got[0], 4'b1010);
            chk4("b2b rsp1", got[1], 4'b0101);
        end

        // Async reset during WR (rewriting the same value keeps contents deterministic)
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 1'b1; cmd_wdata = 4'b0101;
        step();
        cmd_valid = 1'b0;
        chk1("wr-rst mem_we before", mem_we, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("wr-rst mem_we forced", mem_we, 1'b0);
        chk1("wr-rst cmd_ready", cmd_ready, 1'b1);
        #1 rst = 1'b0;
        step();
        chk1("wr-rst no wr_done", wr_done, 1'b0);

        // Async reset during RD_B
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        chk1("rd-rst mem_we", mem_we, 1'b0);
        chk1("rd-rst rsp_valid", rsp_valid, 1'b0);
        chk1("rd-rst cmd_ready", cmd_ready, 1'b1);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("rd-rst no response", rsp_valid, 1'b0);
        end
        do_cmd(1'b0, 1'b0, 4'd0, 4'b1010);
        do_cmd(1'b0, 1'b1, 4'd0, 4'b0101);

        // Reset again (registers now hold non-zero values) and run randomized traffic
        #2 rst = 1'b1;
        #1 check_reset_vals("reset2");
        #1 rst = 1'b0;
        step();
        ref_mem[0] = 4'b1010; ref_mem[1] = 4'b0101;
        ph = 0; m_we = 1'b0; m_addr = 1'b0; m_wd = 4'd0; m_rsp = 4'd0;
        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom);
            cmd_we = 1'($urandom);
            cmd_addr = 1'($urandom);
            cmd_wdata = 4'($urandom);
            rsp_ready = $urandom_range(0, 3) != 0;
            e_done = 1'b0;
            if (ph == 0) begin
                if (cmd_valid) begin
                    m_we = cmd_we; m_addr = cmd_addr; ph = 1;
                    if (cmd_we) m_wd = cmd_wdata;
                end
            end else if (m_we) begin
                ref_mem[m_addr] = m_wd; e_done = 1'b1; ph = 0;
            end else if (ph < 3) begin
                ph++;
            end else if (ph == 3) begin
                m_rsp = ref_mem[m_addr]; ph = 4;
            end else if (rsp_ready) begin
                ph = 0;
            end
            step();
            chk1("rnd cmd_ready", cmd_ready, ph == 0);
            chk1("rnd mem_we", mem_we, ph == 1 && m_we);
            chk1("rnd wr_done", wr_done, e_done);
            chk1("rnd rsp_valid", rsp_valid, ph == 4);
            chk4("rnd rsp_data", rsp_data, m_rsp);
            chk1("rnd mem_addr", mem_addr, m_addr);
            chk4("rnd mem_wdata", mem_wdata, m_wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_req_sequencer.md
# ram_req_sequencer

Request sequencer that sits directly upstream of the single-port 2-word x 4-bit RAM and is its only driver. It accepts one write or read command at a time over a valid/ready handshake and drives the RAM port (mem_we, mem_addr, mem_wdata). It enforces the RAM's two-edge read timing and returns read data on a registered valid/ready response channel. Commands are strictly serialised, so no read/write hazard exists.

## Interface
- DATA_W, 4, data width of the RAM word
- ADDR_W, 1, address width; the RAM holds 2**ADDR_W words
- clk  in  1  rising-edge clock shared with the RAM
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target word
- cmd_wdata  in  DATA_W  write data; ignored for reads
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer takes read data
- rsp_data  out  DATA_W  captured read data
- wr_done  out  1  one-cycle pulse when a write has been committed

## Operation
- All outputs are registered except cmd_ready, which is decoded from state only and never depends on cmd_valid.
- RAM contract:
  - A write occurs on the rising edge where mem_we=1.
  - With mem_we=0, the RAM latches mem_addr on one edge and presents the data on mem_rdata after the following edge.
  - mem_we must stay 0 and mem_addr must stay stable for both of those edges.
- States: IDLE, WR, RD_A, RD_B, RD_C, RSP.
- IDLE, on cmd_valid & cmd_ready:
  - mem_addr <= cmd_addr.
  - Write (cmd_we=1): mem_we <= 1, mem_wdata <= cmd_wdata, go to WR.
  - Read (cmd_we=0): mem_we <= 0, go to RD_A.
  - Otherwise remain in IDLE with mem_we=0 and mem_addr/mem_wdata unchanged.
- WR: the RAM writes on this edge. Then mem_we <= 0, wr_done <= 1 for exactly one cycle, go to IDLE.
- RD_A: the RAM latches the address; go to RD_B.
- RD_B: the RAM drives data; go to RD_C.
- RD_C: rsp_data <= mem_rdata, rsp_valid <= 1, go to RSP.
- RSP:
  - Hold rsp_valid and rsp_data stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, go to IDLE.
- mem_addr and mem_wdata change only on command acceptance.
- Reset values:
  - state IDLE, cmd_ready 1.
  - mem_we 0, mem_addr 0, mem_wdata 0.
  - rsp_valid 0, rsp_data 0, wr_done 0.
- Reset mid-operation:
  - Aborts the command immediately; no response and no wr_done is produced.
  - A write aborted in WR may or may not have reached the RAM.
  - mem_we is forced to 0 asynchronously.

## Timing
- Edge numbering: edge 0 is the acceptance edge.
- Write:
  - mem_we=1 after edge 0; RAM writes at edge 1.
  - wr_done=1 and cmd_ready=1 after edge 1.
  - Next command is accepted at edge 2 at the earliest; throughput is 1 write per 2 cycles.
- Read:
  - mem_addr is valid after edge 0; RAM latches it at edge 1 and drives data at edge 2.
  - Sequencer captures data at edge 3; rsp_valid=1 after edge 3.
  - If rsp_ready is already high, the response is accepted at edge 4, giving cmd_ready=1 after edge 4.
  - Minimum read period is 5 cycles.
- Response back-pressure: rsp_ready low holds RSP indefinitely; rsp_data must not change while rsp_valid=1.
- cmd_valid may drop without acceptance; no command is ever lost once cmd_valid & cmd_ready are sampled high together.
- cmd_valid held high continuously: commands are accepted back-to-back at the rates above.

## Test plan
- Reset, then write addr0=0110, write addr1=1111, read addr0 -> mem_we high for exactly one cycle per write; rsp_data=0110 with rsp_valid rising 3 edges after acceptance.
- Read addr1 after the above -> rsp_data=1111; read addr0 -> 0110, confirming no stale data from the previous address.
- Overwrite addr0=1100, then read addr0 immediately on the next acceptance edge -> 1100; wr_done pulses exactly once.
- Read with rsp_ready held low for 6 cycles -> rsp_valid and rsp_data stay stable and cmd_ready stays 0; cmd_valid asserted meanwhile is not accepted until the edge after rsp_ready=1.
- Back-to-back commands with cmd_valid always high (W0=1010, R0, W1=0101, R1) -> acceptance edges at 0, 2, 7, 9; rsp_data 1010 then 0101.
- rst asserted asynchronously during RD_B -> mem_we=0, rsp_valid=0, cmd_ready=1 immediately; no response follows, and a subsequent read returns the pre-reset contents.
